// File: rtl/data_memory.sv
// Data-side memory for the MEM stage: combinational loads with byte-lane
// forwarding from an in-order store buffer that drains into a single-port
// word array one entry per cycle.
module data_memory #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int BUFFER_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_read_enable,
  input  logic [31:0] memory_read_address,
  output logic [31:0] memory_read_data,
  input  logic        memory_write_enable,
  input  logic [31:0] memory_write_address,
  input  logic [3:0]  memory_write_select,
  input  logic [31:0] memory_write_data,
  output logic        stall
);

  localparam int PW    = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int WORDS = 1 << ADDRESS_WIDTH;

  typedef logic [ADDRESS_WIDTH-1:0] idx_t;

  // Word array: never reset, contents survive a pipeline reset.
  logic [31:0] mem_q [WORDS];

  // Store buffer storage plus circular bookkeeping.
  idx_t          buf_idx_q  [BUFFER_DEPTH];
  logic [3:0]    buf_sel_q  [BUFFER_DEPTH];
  logic [31:0]   buf_data_q [BUFFER_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  idx_t        rd_idx, wr_idx;
  logic        full, enq, drain;
  logic [31:0] fwd_word;

  assign rd_idx = memory_read_address[ADDRESS_WIDTH+1:2];
  assign wr_idx = memory_write_address[ADDRESS_WIDTH+1:2];

  // Byte offsets and high address bits are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{memory_read_address[31:ADDRESS_WIDTH+2], memory_read_address[1:0],
                              memory_write_address[31:ADDRESS_WIDTH+2], memory_write_address[1:0]};

  assign full  = (count_q == CW'(BUFFER_DEPTH));
  assign stall = !reset && full && (memory_read_enable || memory_write_enable);
  assign enq   = !reset && memory_write_enable && !stall;
  // A drain only happens when the array port is free of loads, or when the
  // buffer is full (and then the load is stalled, so the port is still free).
  assign drain = !reset && (count_q != '0) && (!memory_read_enable || full);

  // Array read overlaid with pending stores, oldest first so the youngest byte wins.
  always_comb begin
    logic [PW-1:0] slot;
    fwd_word = mem_q[rd_idx];
    slot     = '0;
    for (int k = 0; k < BUFFER_DEPTH; k++) begin
      slot = head_q + PW'(k);
      if ((CW'(k) < count_q) && (buf_idx_q[slot] == rd_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (buf_sel_q[slot][b]) fwd_word[8*b +: 8] = buf_data_q[slot][8*b +: 8];
        end
      end
    end
  end

  assign memory_read_data = (memory_read_enable && !stall && !reset) ? fwd_word : 32'h0;

  // Pointer and occupancy next-state; pointers wrap naturally at PW bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + 1'b1;
    if (enq)   tail_d = tail_q + 1'b1;
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Buffer bookkeeping with synchronous reset; pending stores are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Buffer payload capture on enqueue.
  always_ff @(posedge clock) begin
    if (enq) begin
      buf_idx_q[tail_q]  <= wr_idx;
      buf_sel_q[tail_q]  <= memory_write_select;
      buf_data_q[tail_q] <= memory_write_data;
    end
  end

  // Head entry drains into the array with per-lane write enables.
  always_ff @(posedge clock) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_sel_q[head_q][b])
          mem_q[buf_idx_q[head_q]][8*b +: 8] <= buf_data_q[head_q][8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the stimulus pushes the expected
// response of every request cycle; a negedge monitor pops and compares.
module tb_data_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic        memory_read_enable;
  logic [31:0] memory_read_address;
  logic [31:0] memory_read_data;
  logic        memory_write_enable;
  logic [31:0] memory_write_address;
  logic [3:0]  memory_write_select;
  logic [31:0] memory_write_data;
  logic        stall;

  data_memory #(.ADDRESS_WIDTH(10), .BUFFER_DEPTH(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .memory_read_enable   (memory_read_enable),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .memory_write_enable  (memory_write_enable),
    .memory_write_address (memory_write_address),
    .memory_write_select  (memory_write_select),
    .memory_write_data    (memory_write_data),
    .stall                (stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic        chk_data;
    logic [31:0] data;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   vid     = 0;

  // Monitor: one expectation per request cycle.
  always @(negedge clock) begin
    if (memory_read_enable || memory_write_enable) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_request: got data=%h stall=%b, required no request", memory_read_data, stall);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (stall !== e.stall) begin
          errors++;
          $display("FAIL v%0d_stall: got %b, required %b", e.id, stall, e.stall);
        end
        if (e.chk_data) begin
          vectors++;
          if (memory_read_data !== e.data) begin
            errors++;
            $display("FAIL v%0d_data: got %h, required %h", e.id, memory_read_data, e.data);
          end
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic re, input logic [31:0] ra,
                     input logic we, input logic [31:0] wa, input logic [3:0] ws,
                     input logic [31:0] wd, input logic chk, input logic [31:0] ed,
                     input logic es);
    exp_t e;
    @(posedge clock);
    #1;
    reset                = rst;
    memory_read_enable   = re;
    memory_read_address  = ra;
    memory_write_enable  = we;
    memory_write_address = wa;
    memory_write_select  = ws;
    memory_write_data    = wd;
    if (re || we) begin
      e.id = vid; e.chk_data = chk; e.data = ed; e.stall = es;
      exp_q.push_back(e);
      vid++;
    end
  endtask

  task automatic idle();                                  cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic ld(input logic [31:0] a, input logic [31:0] d); cyc(0, 1, a, 0, 0, 0, 0, 1, d, 0); endtask
  task automatic st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    cyc(0, 0, 0, 1, a, s, d, 0, 0, 0);
  endtask
  task automatic ldst(input logic [31:0] ra, input logic [31:0] ed, input logic [31:0] wa,
                      input logic [3:0] s, input logic [31:0] wd);
    cyc(0, 1, ra, 1, wa, s, wd, 1, ed, 0);
  endtask

  initial begin
    reset = 1; memory_read_enable = 0; memory_read_address = 0;
    memory_write_enable = 0; memory_write_address = 0;
    memory_write_select = 0; memory_write_data = 0;

    // Reset: load requested but data and stall forced low.
    cyc(1, 1, 32'h0, 0, 0, 0, 0, 1, 32'h0, 0);
    cyc(1, 1, 32'h40, 1, 32'h40, 4'hF, 32'h12345678, 1, 32'h0, 0);

    // Plain store/load, null-select store, byte offset and aliasing.
    st(32'h40, 4'hF, 32'hDEADBEEF);
    idle();
    ld(32'h40, 32'hDEADBEEF);
    st(32'h40, 4'h0, 32'hFFFFFFFF);
    ld(32'h40, 32'hDEADBEEF);
    idle();
    ld(32'h43, 32'hDEADBEEF);
    ld(32'h40 + (32'h1 << 12), 32'hDEADBEEF);

    // Byte forwarding on top of 0x11223344.
    st(32'h80, 4'hF, 32'h11223344);
    idle();
    st(32'h83, 4'b0001, 32'h000000AA);
    ldst(32'h80, 32'h112233AA, 32'h80, 4'b1000, 32'hBB000000);
    ld(32'h80, 32'hBB2233AA);
    ld(32'h80, 32'hBB2233AA);
    idle(); idle();
    ld(32'h80, 32'hBB2233AA);

    // Youngest wins, loads held high elsewhere so nothing drains.
    ldst(32'h40, 32'hDEADBEEF, 32'h100, 4'hF, 32'h01010101);
    ldst(32'h40, 32'hDEADBEEF, 32'h100, 4'hF, 32'h02020202);
    ld(32'h100, 32'h02020202);
    idle(); idle();
    ld(32'h100, 32'h02020202);

    // Full buffer with continuous loads.
    for (int k = 0; k < 4; k++)
      ldst(32'h40, 32'hDEADBEEF, 32'h200 + 4*k, 4'hF, 32'hA0000000 + k);
    cyc(0, 1, 32'h40, 1, 32'h210, 4'hF, 32'hA0000004, 1, 32'h0, 1);     // stall, forced drain
    ldst(32'h40, 32'hDEADBEEF, 32'h210, 4'hF, 32'hA0000004);            // accepted, count back to 4
    cyc(0, 1, 32'h200, 0, 0, 0, 0, 1, 32'h0, 1);                       // still full -> stall
    ld(32'h200, 32'hA0000000);
    ld(32'h210, 32'hA0000004);
    ld(32'h208, 32'hA0000002);
    idle(); idle(); idle();
    ld(32'h20C, 32'hA0000003);
    ld(32'h204, 32'hA0000001);

    // Wrap-around: ten stores with idles interleaved.
    for (int k = 0; k < 10; k++) begin
      st(32'h300 + 4*k, 4'hF, 32'hC0000000 + k);
      if (k % 2 == 1) idle();
    end
    idle();
    for (int k = 0; k < 10; k++) ld(32'h300 + 4*k, 32'hC0000000 + k);

    // Reset with three stores pending: they must vanish.
    ldst(32'h300, 32'hC0000000, 32'h40,  4'hF, 32'h11111111);
    ldst(32'h300, 32'hC0000000, 32'h80,  4'hF, 32'h22222222);
    ldst(32'h300, 32'hC0000000, 32'h100, 4'hF, 32'h33333333);
    cyc(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'h0, 0);
    ld(32'h40,  32'hDEADBEEF);
    ld(32'h80,  32'hBB2233AA);
    ld(32'h100, 32'h02020202);
    idle(); idle();
    ld(32'h40,  32'hDEADBEEF);

    idle();
    repeat (4) @(posedge clock);
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain_scoreboard: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Data-side memory that answers the MEM stage's load/store requests. Reads are combinational, so load data returns in the same cycle. Stores go into a small in-order store buffer and drain one per cycle into a single-port word array. Loads see pending stores through byte-lane forwarding, and `stall` holds the pipeline when the buffer is full.

## Interface
- `ADDRESS_WIDTH`, 10: number of word-index bits; the array holds 2^ADDRESS_WIDTH 32-bit words.
- `BUFFER_DEPTH`, 4: number of store-buffer entries; must be a power of two, ≥2.
- `clock`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `memory_read_enable`  in  1: a load is requested this cycle.
- `memory_read_address`  in  32: load byte address.
- `memory_read_data`  out  32: load word, big-endian lanes.
- `memory_write_enable`  in  1: a store is requested this cycle.
- `memory_write_address`  in  32: store byte address.
- `memory_write_select`  in  4: byte-lane enables; bit3 is `data[31:24]` (offset 0), bit0 is `data[7:0]` (offset 3).
- `memory_write_data`  in  32: store data, already lane-aligned.
- `stall`  out  1: request not serviced this cycle; the requester holds its inputs.

## Operation
- **Word index:** `address[ADDRESS_WIDTH+1:2]`. Bits [1:0] and bits above ADDRESS_WIDTH+1 are ignored, so upper addresses alias. Loads always return the full word.
- **Store buffer:** circular FIFO of {index, select, data}, with head pointer, tail pointer and count.
  - Enqueue when `memory_write_enable && !stall`.
  - A store with select=0000 is accepted and then drains as a no-op.
  - Stores are never merged with each other.
- **Drain:** the head entry is written to the array with per-lane write enables from its select.
  - Drain happens when count>0 and either `memory_read_enable`=0 or count==BUFFER_DEPTH (forced drain).
  - At most one drain per cycle.
  - The array is single-port: a drain and an array read never share a cycle.
- **Load data:** start from the array word at the index. Then overlay every valid buffer entry with a matching index, oldest to youngest, per lane. The youngest write to each byte wins.
- **Same-cycle load and store:** if both enables are high, the load does not see that cycle's store; it sees only entries already in the buffer.
- **`stall` (combinational):**
  - `stall` = (count==BUFFER_DEPTH) && (`memory_read_enable` || `memory_write_enable`).
  - While stalled, `memory_read_data` is 0 and no enqueue happens.
  - The forced drain still occurs, so `stall` lasts exactly one cycle per full event.
- **Enqueue and drain together:** count is unchanged; the pointers advance independently and wrap modulo BUFFER_DEPTH.
- **Reset:**
  - Buffer emptied; pending stores are discarded. Count=0, head=tail=0.
  - While `reset` is high, `stall`=0 and `memory_read_data`=0.
  - Array contents are not cleared.
  - Reset overrides an in-progress drain: no array write occurs in the reset cycle.

## Timing
- Load latency is 0 cycles: `memory_read_data` is valid in the request cycle unless `stall` is high.
- A store is visible to loads from the cycle after acceptance, via forwarding. It reaches the array at the earliest on the next edge without a load.
- Full state:
  - Cycle N: count==BUFFER_DEPTH and a request is present, so `stall`=1 and the head drains.
  - Cycle N+1: count=BUFFER_DEPTH−1, and the held request is serviced.
- Continuous loads with 0<count<BUFFER_DEPTH starve the drain. The buffer then stays at its current occupancy, which is allowed.
- With no requests, the buffer empties at one entry per cycle.

## Test plan
- **Plain store/load:** store 0xDEADBEEF, select 1111, to 0x40. Idle 1 cycle. Load 0x40 → 0xDEADBEEF, `stall`=0, count=0.
- **Byte forwarding:**
  - Setup: array word at 0x80 = 0x11223344.
  - Store 0x000000AA, select 0001, to 0x83, then immediately load 0x80 → 0x112233AA.
  - Store 0xBB000000, select 1000, next cycle, then load → 0xBB2233AA.
  - Verify the array is unchanged until idle cycles occur.
- **Youngest wins:** store 0x01010101 then 0x02020202, both select 1111, to 0x100, back-to-back with loads held high. Load 0x100 → 0x02020202. After 2 idle cycles the array holds 0x02020202.
- **Full buffer:**
  - With BUFFER_DEPTH=4 and `memory_read_enable` held high, issue 4 stores.
  - A 5th store → `stall`=1 for exactly one cycle, `memory_read_data`=0 that cycle, and one forced drain.
  - The 5th store is accepted the next cycle, and count stays 4.
- **Wrap-around:** issue 10 stores to distinct words with idle cycles interleaved, so the pointers wrap twice. All 10 words read back correctly and in order.
- **Reset mid-operation:** assert `reset` with 3 entries pending → next cycle count=0. A load of those addresses returns the prior array contents, and `stall`=0 throughout.
